flash_ctrl_rd_arb: RTL and testbench

FLASH_CTRL_RD_ARB -- requirements
Module: flash_ctrl_rd_arb

---
 rtl/flash_ctrl_rd_arb.sv | 135 +++++++++++++
 tb/tb_flash_ctrl_rd_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_ctrl_rd_arb.sv
// Flash read arbiter: grants the flash read engine to sw or hw, hw priority with a sw anti-starvation limit.
// Optional busy timeout compiled in with FLASH_CTRL_RD_ARB_TIMEOUT_EN.
module flash_ctrl_rd_arb #(
  parameter int AddrW         = 16,
  parameter int MaxHwBurst    = 4,
  parameter int TimeoutCycles = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sw_req_i,
  input  logic [AddrW-1:0] sw_addr_i,
  input  logic [11:0]      sw_num_words_i,
  output logic             sw_gnt_o,
  output logic             sw_done_o,
  output logic [3:0]       sw_err_o,
  input  logic             hw_req_i,
  input  logic [AddrW-1:0] hw_addr_i,
  input  logic [11:0]      hw_num_words_i,
  output logic             hw_gnt_o,
  output logic             hw_done_o,
  output logic [3:0]       hw_err_o,
  output logic             op_start_o,
  output logic [AddrW-1:0] op_addr_o,
  output logic [11:0]      op_num_words_o,
  input  logic             op_done_i,
  input  logic [2:0]       op_err_i,
  output logic             owner_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } st_e;

  localparam logic [2:0] BurstMax = 3'(MaxHwBurst);

  st_e              r_state;
  st_e              w_state_nxt;
  logic [2:0]       r_streak;
  logic [AddrW-1:0] r_addr;
  logic [11:0]      r_num;
  logic             r_owner;

  logic       w_idle;
  logic       w_busy;
  logic       w_legal;
  logic       w_sw_win;
  logic       w_hw_win;
  logic       w_tmo;
  logic       w_fin;
  logic [3:0] w_err;

  // Grants are gated by rst_ni so an asserted reset forces every output low at once.
  assign w_idle   = (r_state == StIdle) && rst_ni;
  assign w_busy   = (r_state == StBusy);
  assign w_legal  = (r_state == StIdle) || (r_state == StBusy) || (r_state == StDone);
  assign w_sw_win = w_idle && sw_req_i && (!hw_req_i || (r_streak == BurstMax));
  assign w_hw_win = w_idle && hw_req_i && !w_sw_win;

`ifdef FLASH_CTRL_RD_ARB_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  // A real completion in the timeout cycle wins over the timeout.
  assign w_tmo = w_busy && !op_done_i && (r_tmo_cnt == 16'(TimeoutCycles - 1));
  assign w_err = op_done_i ? {1'b0, op_err_i} : 4'b1000;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (w_sw_win || w_hw_win) begin
      r_tmo_cnt <= '0;
    end else if (w_busy) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end
`else
  assign w_tmo = 1'b0;
  assign w_err = {1'b0, op_err_i};
`endif

  assign w_fin = w_busy && (op_done_i || w_tmo);

  always_comb begin
    w_state_nxt = StIdle;
    case (r_state)
      StIdle:  w_state_nxt = (w_sw_win || w_hw_win) ? StBusy : StIdle;
      StBusy:  w_state_nxt = w_fin ? StDone : StBusy;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= StIdle;
      r_streak <= '0;
      r_addr   <= '0;
      r_num    <= '0;
      r_owner  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sw_win) begin
        r_addr   <= sw_addr_i;
        r_num    <= sw_num_words_i;
        r_owner  <= 1'b0;
        r_streak <= '0;
      end else if (w_hw_win) begin
        r_addr   <= hw_addr_i;
        r_num    <= hw_num_words_i;
        r_owner  <= 1'b1;
        // Streak only counts hw wins that made a waiting sw request lose.
        if (!sw_req_i) begin
          r_streak <= '0;
        end else if (r_streak != BurstMax) begin
          r_streak <= r_streak + 3'd1;
        end
      end
    end
  end

  assign sw_gnt_o       = w_sw_win;
  assign hw_gnt_o       = w_hw_win;
  assign sw_done_o      = w_fin && !r_owner;
  assign hw_done_o      = w_fin && r_owner;
  assign sw_err_o       = sw_done_o ? w_err : 4'b0000;
  assign hw_err_o       = hw_done_o ? w_err : 4'b0000;
  assign op_start_o     = w_busy;
  assign busy_o         = w_busy;
  assign op_addr_o      = w_legal ? r_addr : '0;
  assign op_num_words_o = w_legal ? r_num : '0;
  assign owner_o        = w_legal && r_owner;

endmodule

// File: tb/tb_flash_ctrl_rd_arb.sv
// Bench for flash_ctrl_rd_arb: directed scenarios plus random traffic against a transaction-level model.
// Timeout scenario runs only when FLASH_CTRL_RD_ARB_TIMEOUT_EN is defined.
module tb_flash_ctrl_rd_arb;
  localparam int AW   = 16;
  localparam int MAXB = 4;
  localparam int TMO  = 16;
`ifdef FLASH_CTRL_RD_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          sw_req_i, hw_req_i;
  logic [AW-1:0] sw_addr_i, hw_addr_i;
  logic [11:0]   sw_num_i, hw_num_i;
  logic          sw_gnt_o, sw_done_o, hw_gnt_o, hw_done_o;
  logic [3:0]    sw_err_o, hw_err_o;
  logic          op_start_o, op_done_i, owner_o, busy_o;
  logic [AW-1:0] op_addr_o;
  logic [11:0]   op_num_o;
  logic [2:0]    op_err_i;

  flash_ctrl_rd_arb #(.AddrW(AW), .MaxHwBurst(MAXB), .TimeoutCycles(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .sw_req_i(sw_req_i), .sw_addr_i(sw_addr_i), .sw_num_words_i(sw_num_i),
    .sw_gnt_o(sw_gnt_o), .sw_done_o(sw_done_o), .sw_err_o(sw_err_o),
    .hw_req_i(hw_req_i), .hw_addr_i(hw_addr_i), .hw_num_words_i(hw_num_i),
    .hw_gnt_o(hw_gnt_o), .hw_done_o(hw_done_o), .hw_err_o(hw_err_o),
    .op_start_o(op_start_o), .op_addr_o(op_addr_o), .op_num_words_o(op_num_o),
    .op_done_i(op_done_i), .op_err_i(op_err_i), .owner_o(owner_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] pack_dut();
    return {21'd0, sw_gnt_o, sw_done_o, sw_err_o, hw_gnt_o, hw_done_o, hw_err_o,
            op_start_o, busy_o, owner_o, op_num_o, op_addr_o};
  endfunction

  // Transaction-level model: an operation in flight, a one-cycle cooldown, and the hw win streak.
  bit          m_busy, m_cool, m_own;
  logic [15:0] m_addr;
  logic [11:0] m_num;
  int          m_streak, m_elapsed;
  bit          g_sw, g_hw;
  bit          gq[$];
  logic        k_sw_gnt, k_hw_gnt, k_sw_done, k_hw_done, k_start, k_busy, k_owner;
  logic [3:0]  k_sw_err, k_hw_err;

  task automatic model_reset();
    m_busy = 0; m_cool = 0; m_own = 0; m_addr = '0; m_num = '0;
    m_streak = 0; m_elapsed = 0;
  endtask

  // Called at posedge+1 with inputs already driven; checks at mid-cycle, returns at next posedge+1.
  task automatic cyc(input string tag);
    bit e_sg, e_hg, e_sd, e_hd, e_st, e_bz, fin;
    logic [3:0] e_se, e_he, err;
    #4;
    e_sg = 0; e_hg = 0; e_sd = 0; e_hd = 0; e_st = 0; e_bz = 0; fin = 0;
    e_se = 0; e_he = 0; err = 0;
    if (!m_busy && !m_cool) begin
      e_sg = sw_req_i && (!hw_req_i || m_streak == MAXB);
      e_hg = hw_req_i && !e_sg;
    end else if (m_busy) begin
      e_st = 1; e_bz = 1;
      fin = op_done_i || (TMO_EN && m_elapsed == TMO - 1);
      err = op_done_i ? {1'b0, op_err_i} : 4'b1000;
      if (fin && m_own) begin e_hd = 1; e_he = err; end
      if (fin && !m_own) begin e_sd = 1; e_se = err; end
    end
    check(tag, pack_dut(), {21'd0, e_sg, e_sd, e_se, e_hg, e_hd, e_he, e_st, e_bz, m_own, m_num, m_addr});
    k_sw_gnt = sw_gnt_o; k_hw_gnt = hw_gnt_o; k_sw_done = sw_done_o; k_hw_done = hw_done_o;
    k_sw_err = sw_err_o; k_hw_err = hw_err_o; k_start = op_start_o; k_busy = busy_o; k_owner = owner_o;
    g_sw = e_sg; g_hw = e_hg;
    if (e_sg) begin
      m_busy = 1; m_own = 0; m_addr = sw_addr_i; m_num = sw_num_i; m_elapsed = 0; m_streak = 0;
      gq.push_back(1'b0);
    end else if (e_hg) begin
      m_busy = 1; m_own = 1; m_addr = hw_addr_i; m_num = hw_num_i; m_elapsed = 0;
      m_streak = sw_req_i ? ((m_streak + 1 > MAXB) ? MAXB : m_streak + 1) : 0;
      gq.push_back(1'b1);
    end else if (m_busy) begin
      if (fin) begin m_busy = 0; m_cool = 1; end
      else m_elapsed++;
    end else if (m_cool) begin
      m_cool = 0;
    end
    @(posedge clk); #1;
  endtask

  bit exp3[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  bit swp, hwp;

  initial begin
    rst_n = 0; sw_req_i = 0; hw_req_i = 0; sw_addr_i = '0; hw_addr_i = '0;
    sw_num_i = '0; hw_num_i = '0; op_done_i = 0; op_err_i = '0;
    model_reset();
    #1 check("rst_outs", pack_dut(), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cyc("idle"); cyc("idle");

    // Single sw read, done six cycles after grant
    sw_req_i = 1; sw_addr_i = 16'h0040; sw_num_i = 12'd3;
    cyc("t1_c0");
    check("t1_gnt", k_sw_gnt, 1);
    sw_req_i = 0;
    for (int i = 1; i <= 6; i++) begin
      op_done_i = (i == 6);
      cyc("t1_busy");
      check("t1_start", k_start, 1);
    end
    check("t1_done", {k_sw_done, k_sw_err}, {1'b1, 4'b0000});
    check("t1_addr", op_addr_o, 16'h0040);
    op_done_i = 0;
    cyc("t1_c7");
    check("t1_busy_fall", k_busy, 0);
    cyc("t1_idle");

    // Simultaneous requests: hw first, then sw
    sw_req_i = 1; sw_addr_i = 16'h0100; sw_num_i = 12'd5;
    hw_req_i = 1; hw_addr_i = 16'h0200; hw_num_i = 12'd7;
    cyc("t2_g");
    check("t2_hw_first", {k_hw_gnt, k_sw_gnt}, 2'b10);
    hw_req_i = 0;
    cyc("t2_b1");
    check("t2_owner_hw", k_owner, 1);
    op_done_i = 1; cyc("t2_b2"); op_done_i = 0;
    cyc("t2_done");
    check("t2_no_gnt_done", k_sw_gnt, 0);
    cyc("t2_idle");
    check("t2_sw_gnt", k_sw_gnt, 1);
    sw_req_i = 0;
    cyc("t2_b3");
    check("t2_owner_sw", k_owner, 0);
    op_done_i = 1; cyc("t2_b4"); op_done_i = 0;
    cyc("t2_d"); cyc("t2_i");

    // Starvation guard: hw and sw both held continuously
    gq.delete();
    sw_req_i = 1; hw_req_i = 1; op_done_i = 1;
    for (int i = 0; i < 200 && gq.size() < 6; i++) cyc("t3");
    sw_req_i = 0; hw_req_i = 0;
    cyc("t3_drain"); cyc("t3_drain"); cyc("t3_drain");
    op_done_i = 0;
    check("t3_count", gq.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < gq.size()) check("t3_order", gq[i], exp3[i]);

    // Error passthrough to the hw owner only
    hw_req_i = 1; hw_addr_i = 16'h0300; hw_num_i = 12'd1; op_err_i = 3'b010;
    cyc("t4_g");
    hw_req_i = 0;
    cyc("t4_b1");
    op_done_i = 1; cyc("t4_b2"); op_done_i = 0;
    check("t4_hw_err", {k_hw_done, k_hw_err}, {1'b1, 4'b0010});
    check("t4_sw_err", {k_sw_done, k_sw_err}, 5'd0);
    cyc("t4_d");
    check("t4_err_clear", k_hw_err, 4'b0000);
    op_err_i = 0;
    cyc("t4_i");

`ifdef FLASH_CTRL_RD_ARB_TIMEOUT_EN
    begin
      int nb;
      bit found;
      nb = 0; found = 0;
      sw_req_i = 1; sw_addr_i = 16'h0400; sw_num_i = 12'd2;
      cyc("t5_g");
      sw_req_i = 0;
      for (int i = 0; i < 40 && !found; i++) begin
        cyc("t5_b");
        nb++;
        if (k_sw_done) found = 1;
      end
      check("t5_busy_cycles", nb, TMO);
      check("t5_err", k_sw_err, 4'b1000);
      sw_req_i = 1;
      cyc("t5_d");
      check("t5_done_quiet", {k_sw_gnt, k_start}, 2'b00);
      cyc("t5_i");
      check("t5_regrant", k_sw_gnt, 1);
      sw_req_i = 0;
      op_done_i = 1; cyc("t5_b2"); op_done_i = 0;
      cyc("t5_d2"); cyc("t5_i2");
    end
`endif

    // Reset in busy cycle 3
    hw_req_i = 1; hw_addr_i = 16'h0500; hw_num_i = 12'd9;
    cyc("t6_g");
    hw_req_i = 0;
    cyc("t6_b1"); cyc("t6_b2");
    #1 rst_n = 0; hw_req_i = 1; op_done_i = 1;
    #1 check("t6_rst_outs", pack_dut(), 64'd0);
    model_reset();
    @(posedge clk); #1;
    check("t6_rst_hold", pack_dut(), 64'd0);
    hw_addr_i = 16'h0600; hw_num_i = 12'd4; op_done_i = 0;
    rst_n = 1;
    cyc("t6_rel");
    check("t6_gnt", k_hw_gnt, 1);
    hw_req_i = 0;
    op_done_i = 1; cyc("t6_b"); op_done_i = 0;
    cyc("t6_d"); cyc("t6_i");

    // Random traffic
    swp = 0; hwp = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!swp) begin
        if ($urandom_range(3) == 0) begin
          swp = 1; sw_addr_i = 16'($urandom); sw_num_i = 12'($urandom);
        end
      end else if ($urandom_range(15) == 0) swp = 0;
      if (!hwp) begin
        if ($urandom_range(2) == 0) begin
          hwp = 1; hw_addr_i = 16'($urandom); hw_num_i = 12'($urandom);
        end
      end else if ($urandom_range(15) == 0) hwp = 0;
      sw_req_i = swp; hw_req_i = hwp;
      op_done_i = ($urandom_range(4) == 0);
      op_err_i = 3'($urandom);
      cyc("rnd");
      if (g_sw) swp = 0;
      if (g_hw) hwp = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
